// File: rtl/apb4_master_bridge.sv
// APB4 requester: one valid/ready command becomes one APB4 transfer and one response; watchdog under APB4_MST_TIMEOUT_EN.
// Latency: psel the cycle after accept, penable one cycle later, rsp_valid the cycle after pready (zero waits: accept+3).
// Backpressure: cmd_ready only while idle, so new commands stall; the response is held stable until rsp_ready.
module apb4_master_bridge #(
  parameter int                 ADDRWIDTH   = 12,
  parameter int                 TOWIDTH     = 8,
  parameter logic [TOWIDTH-1:0] TIMEOUT_CYC = 8'd200
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [31:0]          cmd_wdata,
  input  logic [3:0]           cmd_strb,
  input  logic [2:0]           cmd_prot,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADDRWIDTH-1:0] paddr,
  output logic [31:0]          pwdata,
  output logic [3:0]           pstrb,
  output logic [2:0]           pprot,
  input  logic [31:0]          prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state_q, state_d;
  logic   accept, done, abort, to_hit;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        // cmd_ready is low for the first idle cycle after reset
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          done    = 1'b1;
          state_d = RESP;
        end else if (to_hit) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= (state_d == IDLE);
      psel      <= (state_d == SETUP) || (state_d == ACCESS);
      penable   <= (state_d == ACCESS);
      rsp_valid <= (state_d == RESP);
      if (accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
        pstrb  <= cmd_write ? cmd_strb : 4'h0;
        pprot  <= cmd_prot;
      end
      if (done) begin
        rsp_rdata <= pwrite ? 32'h0 : prdata;
        rsp_err   <= pslverr;
      end else if (abort) begin
        rsp_rdata <= 32'h0;
        rsp_err   <= 1'b1;
      end
    end
  end

`ifdef APB4_MST_TIMEOUT_EN
  // Abort once TIMEOUT_CYC consecutive pready-low ACCESS cycles have elapsed
  localparam logic [TOWIDTH-1:0] TO_LAST = TIMEOUT_CYC - 1'b1;

  logic [TOWIDTH-1:0] to_cnt;

  assign to_hit = !pready && (to_cnt == TO_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      to_cnt      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state_d == ACCESS && state_q != ACCESS) to_cnt <= '0;
      else if (state_q == ACCESS && !pready)      to_cnt <= to_cnt + 1'b1;
      if (done)       rsp_timeout <= 1'b0;
      else if (abort) rsp_timeout <= 1'b1;
    end
  end
`else
  logic to_unused;
  assign to_unused   = ^TIMEOUT_CYC;
  assign to_hit      = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule
